ir_status_unit: RTL and testbench
=================================

Name: ir_status_unit

Overview:
- Upstream neighbour of the microcoded control unit; produces its opcode, carry, zero and cpu_inspect inputs.
- Holds the instruction register, loaded from the data bus, and exposes the opcode field.
- Holds the carry/zero status register, loaded from the ALU.
- Runs the front-panel debug handshake (halt/step/resume) that drives cpu_inspect. cpu_inspect changes only at instruction boundaries, so microcode dispatch never sees it glitch.

Parameters:
WORD_WIDTH, 16, instruction/data bus width
OPCODE_WIDTH, 7, opcode field width
OPCODE_LSB, 9, bit position of opcode LSB in instruction word (opcode = ir[OPCODE_LSB+OPCODE_WIDTH-1:OPCODE_LSB])
SYNC_STAGES, 2, flip-flop depth of debug input synchronisers (min 2)
START_HALTED, 0, 1 = leave reset in HALTED instead of RUN

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high
data_bus  in  WORD_WIDTH  instruction source
ir_load  in  1  control-word strobe: load IR from data_bus
status_load  in  1  control-word strobe: load carry/zero from ALU
alu_carry  in  1  ALU carry out
alu_zero  in  1  ALU zero out
fetch_boundary  in  1  control-word strobe, high one cycle at instruction dispatch
dbg_halt  in  1  asynchronous front-panel halt request
dbg_step  in  1  asynchronous front-panel single step
dbg_resume  in  1  asynchronous front-panel resume
instr  out  WORD_WIDTH  current IR contents
opcode  out  OPCODE_WIDTH  opcode field of IR
carry  out  1  status carry
zero  out  1  status zero
cpu_inspect  out  1  steers microcode dispatch to inspect routine
dbg_halted  out  1  front-panel halted indicator

Behaviour:
- Reset (clock edge with reset=1):
  - instr=0, carry=0, zero=0.
  - Synchronisers and edge detectors cleared; no edge may be detected on the first cycle after reset, even if an input is held high.
  - State = HALTED if START_HALTED else RUN; cpu_inspect=dbg_halted=(state==HALTED).
  - Reset overrides every other input, in any state.
- IR:
  - ir_load=1 -> instr<=data_bus next edge, else hold.
  - opcode is combinational from instr, so it is valid the cycle after load.
- Status:
  - status_load=1 -> carry<=alu_carry, zero<=alu_zero next edge, else hold.
  - ir_load and status_load are independent and may coincide.
- Debug inputs:
  - Each input passes through SYNC_STAGES flops, then a rising-edge detector.
  - Detector output is a one-cycle pulse (halt_p, step_p, resume_p).
  - Latency from input rise to pulse = SYNC_STAGES+1 cycles.
  - A held level produces exactly one pulse.
- FSM states: RUN, HALT_PEND, HALTED, STEP.
  - RUN: halt_p -> HALT_PEND. step_p and resume_p ignored.
  - HALT_PEND: fetch_boundary -> HALTED. resume_p (without fetch_boundary) -> RUN, cancelling the halt.
  - HALTED: resume_p -> RUN. Otherwise step_p -> STEP. resume_p wins over a simultaneous step_p. halt_p ignored.
  - STEP: fetch_boundary -> HALTED. halt_p ignored. resume_p -> RUN.
- Outputs are registered from state:
  - cpu_inspect = dbg_halted = (state==HALTED).
  - Entry into HALTED shows on the outputs the cycle after the fetch_boundary edge.
  - Leaving HALTED clears cpu_inspect one cycle after the pulse.
- Simultaneous events:
  - HALT_PEND with fetch_boundary and resume_p together -> RUN (resume wins).
  - fetch_boundary in RUN or HALTED has no FSM effect.
- The FSM never blocks ir_load or status_load; IR and status stay writable while halted, for inspect microcode.

Decomposition:
- Shared package/include:
  - FSM state encoding constants (RUN=2'd0, HALT_PEND=2'd1, HALTED=2'd2, STEP=2'd3).
  - OPCODE_WIDTH default, shared with the control unit and assembler tables.
- Sub-module dbg_sync_edge: SYNC_STAGES synchroniser plus rising-edge pulse, synchronous reset. Instantiate it three times.

Test Plan:
- Reset then ir_load=1, data_bus=16'hA5C3 -> next cycle instr=16'hA5C3, opcode=7'h52. Load data_bus=16'hFFFF with ir_load=0 -> instr unchanged.
- status_load=1, alu_carry=1, alu_zero=0 -> carry=1, zero=0. Then alu inputs toggle with status_load=0 -> flags hold. Apply ir_load and status_load in the same cycle -> both update.
- Raise dbg_halt (held 20 cycles) in RUN, fetch_boundary pulses 10 cycles later -> cpu_inspect=1 exactly one cycle after that edge, never earlier. Only one halt pulse occurs.
- In HALTED, dbg_step rise -> cpu_inspect=0 at SYNC_STAGES+2 cycles. Next fetch_boundary -> cpu_inspect=1 next cycle.
- In HALTED, dbg_step and dbg_resume rise in the same cycle -> state RUN. A later fetch_boundary does not re-halt.
- Assert reset mid-STEP, with dbg_halt held high: START_HALTED=0 -> cpu_inspect=0, instr=0, carry=0, and no halt occurs from the held input. START_HALTED=1 -> cpu_inspect=1, dbg_halted=1 right after reset.

Source files
------------

// File: rtl/ir_status_unit_pkg.sv
// Shared definitions for the IR/status front end: debug FSM encoding and
// field widths also used by the control unit and assembler tables.
package ir_status_unit_pkg;

    localparam int unsigned OPCODE_WIDTH_DEFAULT = 7;

    typedef enum logic [1:0] {
        StRun      = 2'd0,
        StHaltPend = 2'd1,
        StHalted   = 2'd2,
        StStep     = 2'd3
    } dbg_state_e;

    function automatic dbg_state_e reset_state(input bit start_halted);
        return start_halted ? StHalted : StRun;
    endfunction

endpackage

// File: rtl/dbg_sync_edge.sv
// Synchroniser plus one-cycle rising-edge pulse for an asynchronous
// front-panel input. Pulse appears SYNC_STAGES+1 cycles after the input rise.
module dbg_sync_edge
    import ir_status_unit_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic async_in,
    output logic pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] valid_q;
    logic                   prev_q;
    logic                   prev_valid_q;
    logic                   pulse_q;

    // valid_q tracks which sync stages hold real samples since reset, so a level
    // already high at reset release is never mistaken for a rising edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q       <= '0;
            valid_q      <= '0;
            prev_q       <= 1'b0;
            prev_valid_q <= 1'b0;
            pulse_q      <= 1'b0;
        end else begin
            sync_q       <= {sync_q[SYNC_STAGES-2:0], async_in};
            valid_q      <= {valid_q[SYNC_STAGES-2:0], 1'b1};
            prev_q       <= sync_q[SYNC_STAGES-1];
            prev_valid_q <= valid_q[SYNC_STAGES-1];
            pulse_q      <= sync_q[SYNC_STAGES-1] & ~prev_q & prev_valid_q;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/ir_status_unit.sv
// Instruction register, carry/zero status and the front-panel halt/step/resume
// handshake feeding the microcoded control unit's dispatch inputs.
module ir_status_unit
    import ir_status_unit_pkg::*;
#(
    parameter int unsigned WORD_WIDTH   = 16,
    parameter int unsigned OPCODE_WIDTH = OPCODE_WIDTH_DEFAULT,
    parameter int unsigned OPCODE_LSB   = 9,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter bit          START_HALTED = 1'b0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [WORD_WIDTH-1:0]   data_bus,
    input  logic                    ir_load,
    input  logic                    status_load,
    input  logic                    alu_carry,
    input  logic                    alu_zero,
    input  logic                    fetch_boundary,
    input  logic                    dbg_halt,
    input  logic                    dbg_step,
    input  logic                    dbg_resume,
    output logic [WORD_WIDTH-1:0]   instr,
    output logic [OPCODE_WIDTH-1:0] opcode,
    output logic                    carry,
    output logic                    zero,
    output logic                    cpu_inspect,
    output logic                    dbg_halted
);

    logic [WORD_WIDTH-1:0] instr_q;
    logic                  carry_q;
    logic                  zero_q;
    dbg_state_e            state_q;
    dbg_state_e            state_d;
    logic                  halted_q;
    logic                  halt_p;
    logic                  step_p;
    logic                  resume_p;

    dbg_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_halt_sync (
        .clock    (clock),
        .reset    (reset),
        .async_in (dbg_halt),
        .pulse    (halt_p)
    );

    dbg_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_step_sync (
        .clock    (clock),
        .reset    (reset),
        .async_in (dbg_step),
        .pulse    (step_p)
    );

    dbg_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_resume_sync (
        .clock    (clock),
        .reset    (reset),
        .async_in (dbg_resume),
        .pulse    (resume_p)
    );

    // IR and status stay writable in every debug state so inspect microcode works.
    always_ff @(posedge clock) begin
        if (reset) begin
            instr_q <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            if (ir_load) begin
                instr_q <= data_bus;
            end
            if (status_load) begin
                carry_q <= alu_carry;
                zero_q  <= alu_zero;
            end
        end
    end

    // Resume always wins; halting only completes on an instruction boundary.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun: begin
                if (halt_p) state_d = StHaltPend;
            end
            StHaltPend: begin
                if (resume_p)            state_d = StRun;
                else if (fetch_boundary) state_d = StHalted;
            end
            StHalted: begin
                if (resume_p)    state_d = StRun;
                else if (step_p) state_d = StStep;
            end
            StStep: begin
                if (resume_p)            state_d = StRun;
                else if (fetch_boundary) state_d = StHalted;
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= reset_state(START_HALTED);
            halted_q <= START_HALTED;
        end else begin
            state_q  <= state_d;
            halted_q <= (state_d == StHalted);
        end
    end

    assign instr       = instr_q;
    assign opcode      = instr_q[OPCODE_LSB +: OPCODE_WIDTH];
    assign carry       = carry_q;
    assign zero        = zero_q;
    assign cpu_inspect = halted_q;
    assign dbg_halted  = halted_q;

endmodule

// File: tb/tb_ir_status_unit.sv
// Scoreboard bench for ir_status_unit: expectations are queued against a cycle
// number when stimulus is driven and compared on the falling edge of that cycle.
module tb_ir_status_unit;

    localparam int unsigned SYNC_STAGES = 2;

    logic        clock;
    logic        reset;
    logic [15:0] data_bus;
    logic        ir_load;
    logic        status_load;
    logic        alu_carry;
    logic        alu_zero;
    logic        fetch_boundary;
    logic        dbg_halt;
    logic        dbg_step;
    logic        dbg_resume;
    logic [15:0] instr;
    logic [6:0]  opcode;
    logic        carry;
    logic        zero;
    logic        cpu_inspect;
    logic        dbg_halted;
    logic [15:0] instr_h;
    logic [6:0]  opcode_h;
    logic        carry_h;
    logic        zero_h;
    logic        cpu_inspect_h;
    logic        dbg_halted_h;

    ir_status_unit #(.SYNC_STAGES(SYNC_STAGES), .START_HALTED(1'b0)) dut (
        .clock          (clock),
        .reset          (reset),
        .data_bus       (data_bus),
        .ir_load        (ir_load),
        .status_load    (status_load),
        .alu_carry      (alu_carry),
        .alu_zero       (alu_zero),
        .fetch_boundary (fetch_boundary),
        .dbg_halt       (dbg_halt),
        .dbg_step       (dbg_step),
        .dbg_resume     (dbg_resume),
        .instr          (instr),
        .opcode         (opcode),
        .carry          (carry),
        .zero           (zero),
        .cpu_inspect    (cpu_inspect),
        .dbg_halted     (dbg_halted)
    );

    ir_status_unit #(.SYNC_STAGES(SYNC_STAGES), .START_HALTED(1'b1)) dut_h (
        .clock          (clock),
        .reset          (reset),
        .data_bus       (data_bus),
        .ir_load        (ir_load),
        .status_load    (status_load),
        .alu_carry      (alu_carry),
        .alu_zero       (alu_zero),
        .fetch_boundary (fetch_boundary),
        .dbg_halt       (dbg_halt),
        .dbg_step       (dbg_step),
        .dbg_resume     (dbg_resume),
        .instr          (instr_h),
        .opcode         (opcode_h),
        .carry          (carry_h),
        .zero           (zero_h),
        .cpu_inspect    (cpu_inspect_h),
        .dbg_halted     (dbg_halted_h)
    );

    typedef enum int {
        SelInstr, SelOpcode, SelCarry, SelZero, SelInspect, SelHalted, SelInspectH, SelHaltedH
    } sel_e;

    typedef struct {
        int          at;
        string       tag;
        sel_e        sel;
        logic [31:0] exp;
    } sb_t;

    sb_t sb[$];
    int  cyc    = 0;
    int  checks = 0;
    int  errors = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] observe(input sel_e sel);
        case (sel)
            SelInstr:    return {16'd0, instr};
            SelOpcode:   return {25'd0, opcode};
            SelCarry:    return {31'd0, carry};
            SelZero:     return {31'd0, zero};
            SelInspect:  return {31'd0, cpu_inspect};
            SelHalted:   return {31'd0, dbg_halted};
            SelInspectH: return {31'd0, cpu_inspect_h};
            default:     return {31'd0, dbg_halted_h};
        endcase
    endfunction

    always @(negedge clock) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].at <= cyc) begin
                if (sb[i].at == cyc) check(sb[i].tag, observe(sb[i].sel), sb[i].exp);
                else check({sb[i].tag, "_late"}, cyc, sb[i].at);
                sb.delete(i);
            end
        end
    end

    task automatic expect_at(input string tag, input sel_e sel, input logic [31:0] exp,
                             input int at);
        sb_t e;
        e.at  = at;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic expect_inspect(input string tag, input logic exp, input int from,
                                  input int to);
        for (int c = from; c <= to; c++) expect_at(tag, SelInspect, {31'd0, exp}, c);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset(input int n);
        reset = 1'b1;
        repeat (n) tick();
        expect_at("rst_instr", SelInstr, 32'h0, cyc);
        expect_at("rst_opcode", SelOpcode, 32'h0, cyc);
        expect_at("rst_carry", SelCarry, 32'h0, cyc);
        expect_at("rst_zero", SelZero, 32'h0, cyc);
        expect_at("rst_inspect", SelInspect, 32'h0, cyc);
        expect_at("rst_halted", SelHalted, 32'h0, cyc);
        expect_at("rst_inspect_sh", SelInspectH, 32'h1, cyc);
        expect_at("rst_halted_sh", SelHaltedH, 32'h1, cyc);
        reset = 1'b0;
    endtask

    task automatic halt_to_halted();
        dbg_halt = 1'b1;
        repeat (SYNC_STAGES + 2) tick();
        fetch_boundary = 1'b1;
        expect_at("halt_enter", SelInspect, 32'h1, cyc + 1);
        tick();
        fetch_boundary = 1'b0;
        dbg_halt = 1'b0;
        repeat (4) tick();
    endtask

    int b;
    int m;

    initial begin
        reset = 1'b1;
        data_bus = '0;
        ir_load = 1'b0;
        status_load = 1'b0;
        alu_carry = 1'b0;
        alu_zero = 1'b0;
        fetch_boundary = 1'b0;
        dbg_halt = 1'b0;
        dbg_step = 1'b0;
        dbg_resume = 1'b0;
        apply_reset(2);
        tick();

        // IR load and hold
        ir_load = 1'b1;
        data_bus = 16'hA5C3;
        expect_at("ir_load", SelInstr, 32'hA5C3, cyc + 1);
        expect_at("ir_opcode", SelOpcode, 32'h52, cyc + 1);
        tick();
        ir_load = 1'b0;
        data_bus = 16'hFFFF;
        expect_at("ir_hold", SelInstr, 32'hA5C3, cyc + 1);
        tick();

        // Status load, hold, and simultaneous with IR
        status_load = 1'b1;
        alu_carry = 1'b1;
        alu_zero = 1'b0;
        expect_at("st_carry", SelCarry, 32'h1, cyc + 1);
        expect_at("st_zero", SelZero, 32'h0, cyc + 1);
        tick();
        status_load = 1'b0;
        alu_carry = 1'b0;
        alu_zero = 1'b1;
        expect_at("st_hold_c", SelCarry, 32'h1, cyc + 1);
        expect_at("st_hold_z", SelZero, 32'h0, cyc + 1);
        tick();
        ir_load = 1'b1;
        status_load = 1'b1;
        data_bus = 16'h1234;
        expect_at("both_instr", SelInstr, 32'h1234, cyc + 1);
        expect_at("both_opcode", SelOpcode, 32'h09, cyc + 1);
        expect_at("both_carry", SelCarry, 32'h0, cyc + 1);
        expect_at("both_zero", SelZero, 32'h1, cyc + 1);
        tick();
        ir_load = 1'b0;
        status_load = 1'b0;
        tick();

        // Held halt, boundary 10 cycles later; then resume while halt still held
        b = cyc;
        dbg_halt = 1'b1;
        expect_inspect("halt_early", 1'b0, b + 1, b + 10);
        expect_at("halted_early", SelHalted, 32'h0, b + 10);
        repeat (10) tick();
        fetch_boundary = 1'b1;
        expect_at("halt_boundary", SelInspect, 32'h1, b + 11);
        expect_at("halted_boundary", SelHalted, 32'h1, b + 11);
        tick();
        fetch_boundary = 1'b0;
        tick();
        m = cyc;
        dbg_resume = 1'b1;
        expect_inspect("resume_wait", 1'b1, m + 1, m + SYNC_STAGES + 1);
        expect_at("resume_exit", SelInspect, 32'h0, m + SYNC_STAGES + 2);
        repeat (4) tick();
        dbg_resume = 1'b0;
        repeat (4) tick();
        dbg_halt = 1'b0;
        repeat (2) tick();
        fetch_boundary = 1'b1;
        expect_inspect("single_halt_pulse", 1'b0, cyc + 1, cyc + 2);
        tick();
        fetch_boundary = 1'b0;
        tick();

        // Single step from HALTED
        halt_to_halted();
        m = cyc;
        dbg_step = 1'b1;
        expect_inspect("step_wait", 1'b1, m + 1, m + SYNC_STAGES + 1);
        expect_at("step_exit", SelInspect, 32'h0, m + SYNC_STAGES + 2);
        expect_at("step_halted", SelHalted, 32'h0, m + SYNC_STAGES + 2);
        repeat (4) tick();
        dbg_step = 1'b0;
        for (int i = 0; i < 3; i++) begin
            expect_at("step_running", SelInspect, 32'h0, cyc + 1);
            tick();
        end
        fetch_boundary = 1'b1;
        expect_at("step_rehalt", SelInspect, 32'h1, cyc + 1);
        tick();
        fetch_boundary = 1'b0;
        repeat (4) tick();

        // Step and resume together in HALTED: resume wins
        m = cyc;
        dbg_step = 1'b1;
        dbg_resume = 1'b1;
        expect_inspect("stres_wait", 1'b1, m + 1, m + SYNC_STAGES + 1);
        expect_at("stres_exit", SelInspect, 32'h0, m + SYNC_STAGES + 2);
        repeat (4) tick();
        dbg_step = 1'b0;
        dbg_resume = 1'b0;
        repeat (3) tick();
        fetch_boundary = 1'b1;
        expect_inspect("stres_no_rehalt", 1'b0, cyc + 1, cyc + 2);
        tick();
        fetch_boundary = 1'b0;
        repeat (3) tick();

        // HALT_PEND with boundary and resume together: resume wins
        dbg_halt = 1'b1;
        repeat (SYNC_STAGES + 2) tick();
        dbg_halt = 1'b0;
        m = cyc;
        dbg_resume = 1'b1;
        repeat (SYNC_STAGES + 1) tick();
        fetch_boundary = 1'b1;
        expect_inspect("pend_resume_wins", 1'b0, m + SYNC_STAGES + 2, m + SYNC_STAGES + 3);
        tick();
        fetch_boundary = 1'b0;
        dbg_resume = 1'b0;
        repeat (2) tick();
        fetch_boundary = 1'b1;
        expect_at("pend_cancelled", SelInspect, 32'h0, cyc + 1);
        tick();
        fetch_boundary = 1'b0;
        repeat (4) tick();

        // Loads while halted, then reset mid-STEP with halt held high
        halt_to_halted();
        ir_load = 1'b1;
        status_load = 1'b1;
        data_bus = 16'hBEEF;
        alu_carry = 1'b1;
        alu_zero = 1'b1;
        expect_at("halted_instr", SelInstr, 32'hBEEF, cyc + 1);
        expect_at("halted_carry", SelCarry, 32'h1, cyc + 1);
        expect_at("halted_zero", SelZero, 32'h1, cyc + 1);
        expect_at("halted_inspect", SelInspect, 32'h1, cyc + 1);
        tick();
        ir_load = 1'b0;
        status_load = 1'b0;
        dbg_step = 1'b1;
        repeat (SYNC_STAGES + 3) tick();
        expect_at("in_step", SelInspect, 32'h0, cyc);
        dbg_step = 1'b0;
        dbg_halt = 1'b1;
        apply_reset(2);
        for (int i = 0; i < 16; i++) begin
            fetch_boundary = (i % 4 == 2);
            expect_at("held_halt_ignored", SelInspect, 32'h0, cyc + 1);
            expect_at("held_halt_sh", SelInspectH, 32'h1, cyc + 1);
            tick();
        end
        fetch_boundary = 1'b0;
        dbg_halt = 1'b0;

        for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
        check("sb_drain", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
